shot_scheduler: RTL and testbench
=================================

Name: shot_scheduler

Overview:
Owns the pool of player projectiles for the shooter game: allocates a slot when the player fires, advances every live shot once per frame, and retires shots on hit or top-of-screen. One shared subtract/compare datapath is time-multiplexed across slots by a per-frame sequencer. Sits beside the player block: consumes its x/y position, feeds the draw mux (is_shot) and collision logic (slot read port, hit input).

Parameters:
NUM_SHOTS, 4, slot count (fixed at 4; slot index 2 bits)
SHOT_STEP, 10'd4, pixels moved up per frame
SHOT_Y_MIN, 10'd0, top boundary
SPAWN_OFFSET, 10'd8, spawn y = player_y_pos - SPAWN_OFFSET
COOLDOWN_FRAMES, 4'd15, frames blocked after an accepted fire
SHOT_W, 10'd1, half-width for draw
SHOT_H, 10'd3, half-height for draw

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_clk  in  1  frame strobe (vsync-derived)
fire  in  1  fire button, level
player_x_pos  in  10  player centre x
player_y_pos  in  10  player centre y
hit_valid  in  1  collision logic retires a shot this cycle
hit_slot  in  2  slot retired by hit_valid
rd_slot  in  2  slot select for read port
DrawX, DrawY  in  10 each  current VGA pixel
rd_x, rd_y  out  10 each  position of rd_slot (combinational)
shot_active  out  4  per-slot live flag
shot_count  out  3  popcount of shot_active
fire_accepted  out  1  one-cycle pulse on spawn
busy  out  1  sequencer not IDLE
is_shot  out  1  DrawX/DrawY inside any live shot

Behaviour:
- Reset (sync, active-high): all slots free, x/y = 0, cooldown = 0, fire_req = 0, FSM = IDLE, edge detector cleared. All outputs 0 the cycle after Reset sampled high; Reset mid-sequence aborts it, no partial updates survive.
- frame_tick: frame_clk sampled into a delay register; tick is a registered one-cycle pulse, high 2 Clk after frame_clk rises.
- FSM: IDLE -> (tick) ADV0 -> ADV1 -> ADV2 -> ADV3 -> SPAWN -> IDLE. busy = 1 in every non-IDLE state. Sequence is 5 cycles; ticks arriving while busy are dropped (cannot occur at VGA rates).
- On tick (IDLE): fire_req <= fire; cooldown_ok <= (cooldown == 0); if cooldown != 0, cooldown decrements by 1.
- ADVn: if slot n live: y < SHOT_Y_MIN + SHOT_STEP -> slot freed, y held; else y <= y - SHOT_STEP. Free slot: no change. x never changes.
- SPAWN: accept iff fire_req & cooldown_ok & any free slot & player_y_pos >= SPAWN_OFFSET. Accept: lowest-index free slot (mask as of this cycle, so slots retired earlier in this sequence are reusable) gets x = player_x_pos, y = player_y_pos - SPAWN_OFFSET, live = 1; cooldown <= COOLDOWN_FRAMES; fire_accepted = 1 this cycle only. New shot not advanced until next tick.
- Held fire therefore repeats every COOLDOWN_FRAMES+1 ticks (16 at default).
- hit_valid: any state, frees hit_slot the next edge; hit on a free slot ignored. Same cycle as ADVn of that slot: hit wins, y not updated. Same cycle as SPAWN choosing that slot: spawn wins (slot was free, hit ignored).
- shot_count, shot_active registered state; rd_x/rd_y return stored values even for free slots.
- is_shot: combinational; 1 iff some live slot has |DrawX - x| <= SHOT_W and |DrawY - y| <= SHOT_H, differences computed signed 11-bit (no wrap at 0).

Test Plan:
1. Reset; player (320,450); fire=1; one frame_clk rise -> after ~7 Clk: slot0 live, rd_x=320, rd_y=442, fire_accepted single pulse in SPAWN, shot_count=1, busy high exactly 5 cycles.
2. fire released, next tick -> slot0 y=438; cooldown 14; no accept pulse.
3. fire held 65 ticks from reset -> accepts at ticks 0,16,32,48 (slots 0..3); tick 64 rejected (all live, no pulse), shot_count=4.
4. Slot0 at y=5, no fire: tick -> y=1; next tick -> slot0 freed, y stays 1, shot_count decrements.
5. Slots 0,1 live; hit_valid with hit_slot=1 coincident with ADV1 -> slot1 freed, y unchanged; next accepted fire fills slot1 while slot0 stays live.
6. Live shot at (320,442): DrawX=321,DrawY=445 -> is_shot=1; DrawX=322 -> 0; DrawY=438 -> 0. Reset asserted during ADV2 -> next cycle shot_active=0, busy=0, is_shot=0.

Source files
------------

// File: rtl/shot_if.sv
// Bus between the shot scheduler and its neighbours: the player block,
// collision logic and the draw mux.
interface shot_if;
  logic       frame_clk;
  logic       fire;
  logic [9:0] player_x_pos;
  logic [9:0] player_y_pos;
  logic       hit_valid;
  logic [1:0] hit_slot;
  logic [1:0] rd_slot;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic [3:0] shot_active;
  logic [2:0] shot_count;
  logic       fire_accepted;
  logic       busy;
  logic       is_shot;

  modport master (
    output frame_clk, fire, player_x_pos, player_y_pos, hit_valid, hit_slot,
           rd_slot, DrawX, DrawY,
    input  rd_x, rd_y, shot_active, shot_count, fire_accepted, busy, is_shot
  );

  modport slave (
    input  frame_clk, fire, player_x_pos, player_y_pos, hit_valid, hit_slot,
           rd_slot, DrawX, DrawY,
    output rd_x, rd_y, shot_active, shot_count, fire_accepted, busy, is_shot
  );
endinterface

// File: rtl/shot_scheduler.sv
// Player projectile pool. Each frame tick runs one sequence that advances
// every slot in turn through a shared datapath, then tries to spawn.
module shot_scheduler #(
  parameter int         NUM_SHOTS       = 4,
  parameter logic [9:0] SHOT_STEP       = 10'd4,
  parameter logic [9:0] SHOT_Y_MIN      = 10'd0,
  parameter logic [9:0] SPAWN_OFFSET    = 10'd8,
  parameter logic [3:0] COOLDOWN_FRAMES = 4'd15,
  parameter logic [9:0] SHOT_W          = 10'd1,
  parameter logic [9:0] SHOT_H          = 10'd3
) (
  input logic  Clk,
  input logic  Reset,
  shot_if.slave bus
);
  // ADVn encodings equal n so the low bits select the slot being advanced
  typedef enum logic [2:0] {
    ADV0 = 3'd0, ADV1 = 3'd1, ADV2 = 3'd2, ADV3 = 3'd3, IDLE = 3'd4, SPAWN = 3'd5
  } state_t;

  state_t                     state;
  logic                       fc_s, fc_d, tick;
  logic [NUM_SHOTS-1:0]       live;
  logic [NUM_SHOTS-1:0][9:0]  xs, ys;
  logic [3:0]                 cooldown;
  logic                       fire_req, cooldown_ok;
  logic [1:0]                 adv_slot, spawn_slot;
  logic                       any_free, spawn_ok, is_shot_c;
  logic [2:0]                 count_c;
  logic signed [10:0]         dx, dy;
  logic [10:0]                adx, ady;

  assign adv_slot = state[1:0];

  always_comb begin
    spawn_slot = '0;
    any_free   = 1'b0;
    for (int i = NUM_SHOTS-1; i >= 0; i--)
      if (!live[i]) begin
        spawn_slot = 2'(i);
        any_free   = 1'b1;
      end
  end

  assign spawn_ok = (state == SPAWN) && fire_req && cooldown_ok && any_free &&
                    (bus.player_y_pos >= SPAWN_OFFSET);

  always_comb begin
    count_c = '0;
    for (int i = 0; i < NUM_SHOTS; i++) count_c = count_c + 3'(live[i]);
  end

  // Differences are taken in 11-bit signed so shots near x/y = 0 don't wrap
  always_comb begin
    is_shot_c = 1'b0;
    dx = '0; dy = '0; adx = '0; ady = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      dx  = $signed({1'b0, bus.DrawX}) - $signed({1'b0, xs[i]});
      dy  = $signed({1'b0, bus.DrawY}) - $signed({1'b0, ys[i]});
      adx = dx[10] ? 11'(-dx) : 11'(dx);
      ady = dy[10] ? 11'(-dy) : 11'(dy);
      if (live[i] && adx <= {1'b0, SHOT_W} && ady <= {1'b0, SHOT_H}) is_shot_c = 1'b1;
    end
  end

  assign bus.rd_x          = xs[bus.rd_slot];
  assign bus.rd_y          = ys[bus.rd_slot];
  assign bus.shot_active   = live;
  assign bus.shot_count    = count_c;
  assign bus.fire_accepted = spawn_ok;
  assign bus.busy          = (state != IDLE);
  assign bus.is_shot       = is_shot_c;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      fc_s        <= 1'b0;
      fc_d        <= 1'b0;
      tick        <= 1'b0;
      live        <= '0;
      xs          <= '0;
      ys          <= '0;
      cooldown    <= '0;
      fire_req    <= 1'b0;
      cooldown_ok <= 1'b0;
    end else begin
      fc_s <= bus.frame_clk;
      fc_d <= fc_s;
      tick <= fc_s & ~fc_d;
      case (state)
        IDLE: if (tick) begin
          state       <= ADV0;
          fire_req    <= bus.fire;
          cooldown_ok <= (cooldown == '0);
          if (cooldown != '0) cooldown <= cooldown - 4'd1;
        end
        ADV0, ADV1, ADV2, ADV3: begin
          state <= (state == ADV3) ? SPAWN : state_t'(state + 3'd1);
          if (live[adv_slot] && !(bus.hit_valid && bus.hit_slot == adv_slot)) begin
            if (ys[adv_slot] < SHOT_Y_MIN + SHOT_STEP) live[adv_slot] <= 1'b0;
            else                                       ys[adv_slot]   <= ys[adv_slot] - SHOT_STEP;
          end
        end
        SPAWN: begin
          state <= IDLE;
          if (spawn_ok) begin
            live[spawn_slot] <= 1'b1;
            xs[spawn_slot]   <= bus.player_x_pos;
            ys[spawn_slot]   <= bus.player_y_pos - SPAWN_OFFSET;
            cooldown         <= COOLDOWN_FRAMES;
          end
        end
        default: state <= IDLE;
      endcase
      // A hit on the slot being spawned into targets a free slot, so spawn wins
      if (bus.hit_valid && !(spawn_ok && bus.hit_slot == spawn_slot))
        live[bus.hit_slot] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shot_scheduler.sv
// Directed bench for shot_scheduler: frame-level behavioural model checked
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_shot_scheduler;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  shot_if bus();

  shot_scheduler dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [3:0] m_live;
  int       m_x[4], m_y[4];
  int       m_cd, m_phase, m_due;
  bit       m_freq, m_cok, m_prev;

  function automatic bit m_accept();
    return (m_phase == 4) && m_freq && m_cok && (m_live != 4'hF) &&
           (int'(bus.player_y_pos) >= 8);
  endfunction

  function automatic bit m_is_shot();
    int ax, ay;
    for (int i = 0; i < 4; i++) begin
      ax = int'(bus.DrawX) - m_x[i]; if (ax < 0) ax = -ax;
      ay = int'(bus.DrawY) - m_y[i]; if (ay < 0) ay = -ay;
      if (m_live[i] && ax <= 1 && ay <= 3) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    m_phase = -1;
    forever begin
      bit start, acc;
      int sp;
      @(posedge Clk);
      if (Reset) begin
        m_live = '0;
        for (int i = 0; i < 4; i++) begin m_x[i] = 0; m_y[i] = 0; end
        m_cd = 0; m_freq = 0; m_cok = 0; m_phase = -1; m_prev = 0; m_due = 0;
      end else begin
        // the sequence starts two edges after the edge that first sees frame_clk high
        start = (m_due == 1);
        if (m_due > 0) m_due--;
        if (bus.frame_clk && !m_prev) m_due = 2;
        m_prev = bus.frame_clk;
        acc = m_accept();
        sp  = -1;
        if (m_phase == -1) begin
          if (start) begin
            m_freq = bus.fire; m_cok = (m_cd == 0);
            if (m_cd > 0) m_cd--;
            m_phase = 0;
          end
        end else if (m_phase < 4) begin
          if (m_live[m_phase] && !(bus.hit_valid && int'(bus.hit_slot) == m_phase)) begin
            if (m_y[m_phase] < 4) m_live[m_phase] = 1'b0;
            else                  m_y[m_phase] -= 4;
          end
          m_phase++;
        end else begin
          if (acc) begin
            for (int i = 3; i >= 0; i--) if (!m_live[i]) sp = i;
            m_live[sp] = 1'b1;
            m_x[sp] = int'(bus.player_x_pos);
            m_y[sp] = int'(bus.player_y_pos) - 8;
            m_cd = 15;
          end
          m_phase = -1;
        end
        if (bus.hit_valid && sp != int'(bus.hit_slot)) m_live[bus.hit_slot] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      chk("shot_active", bus.shot_active, m_live);
      chk("shot_count", bus.shot_count, $countones(m_live));
      chk("busy", bus.busy, m_phase != -1);
      chk("fire_accepted", bus.fire_accepted, m_accept());
      chk("is_shot", bus.is_shot, m_is_shot());
      chk("rd_x", bus.rd_x, m_x[bus.rd_slot]);
      chk("rd_y", bus.rd_y, m_y[bus.rd_slot]);
    end
  end

  // ---------------- stimulus ----------------
  int f_acc, f_busy, f_live_at;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic rd(input logic [1:0] s, output int x, output int y);
    bus.rd_slot = s;
    #1;
    x = int'(bus.rd_x);
    y = int'(bus.rd_y);
  endtask

  // One frame: frame_clk high for 3 edges, 9 edges total; optional hit at edge hit_at
  task automatic frame(input int hit_at = 0, input logic [1:0] hs = 2'd0);
    int c0;
    c0 = int'(bus.shot_count);
    f_acc = 0; f_busy = 0; f_live_at = 0;
    bus.frame_clk = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i == hit_at) begin bus.hit_valid = 1'b1; bus.hit_slot = hs; end
      step(1);
      bus.hit_valid = 1'b0;
      if (i == 3) bus.frame_clk = 1'b0;
      f_acc  += int'(bus.fire_accepted);
      f_busy += int'(bus.busy);
      if (f_live_at == 0 && int'(bus.shot_count) != c0) f_live_at = i;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int x, y, n;
    bus.frame_clk = 0; bus.fire = 0; bus.player_x_pos = 0; bus.player_y_pos = 0;
    bus.hit_valid = 0; bus.hit_slot = 0; bus.rd_slot = 0; bus.DrawX = 0; bus.DrawY = 0;
    do_reset();
    chk("rst_active", bus.shot_active, 0);
    chk("rst_count", bus.shot_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_accept", bus.fire_accepted, 0);
    chk("rst_is_shot", bus.is_shot, 0);

    // first spawn
    bus.player_x_pos = 10'd320; bus.player_y_pos = 10'd450; bus.fire = 1'b1;
    frame();
    chk("t1_busy_cycles", f_busy, 5);
    chk("t1_accept_pulses", f_acc, 1);
    chk("t1_live_at_edge", f_live_at, 8);
    chk("t1_count", bus.shot_count, 1);
    rd(2'd0, x, y);
    chk("t1_x", x, 320);
    chk("t1_y", y, 442);

    // advance, fire released
    bus.fire = 1'b0;
    frame();
    rd(2'd0, x, y);
    chk("t2_y", y, 438);
    chk("t2_accept_pulses", f_acc, 0);

    // held fire repeats every 16 ticks; fifth try finds no free slot
    do_reset();
    bus.fire = 1'b1;
    for (int f = 0; f <= 64; f++) begin
      frame();
      chk($sformatf("t3_accept_tick%0d", f), f_acc, (f % 16 == 0 && f < 64) ? 1 : 0);
    end
    chk("t3_count", bus.shot_count, 4);
    rd(2'd3, x, y);
    chk("t3_slot3_y", y, 378);
    rd(2'd0, x, y);
    chk("t3_slot0_y", y, 186);

    // top-of-screen retirement
    do_reset();
    bus.player_y_pos = 10'd13; bus.fire = 1'b1;
    frame();
    bus.fire = 1'b0;
    rd(2'd0, x, y);
    chk("t4_spawn_y", y, 5);
    frame();
    rd(2'd0, x, y);
    chk("t4_y1", y, 1);
    chk("t4_count1", bus.shot_count, 1);
    frame();
    rd(2'd0, x, y);
    chk("t4_held_y", y, 1);
    chk("t4_count0", bus.shot_count, 0);

    // hit coincident with ADV1, then refill
    do_reset();
    bus.player_y_pos = 10'd450; bus.fire = 1'b1;
    for (int f = 0; f <= 16; f++) frame();
    bus.fire = 1'b0;
    chk("t5_two_live", bus.shot_active, 4'b0011);
    frame(5, 2'd1);
    chk("t5_after_hit", bus.shot_active, 4'b0001);
    rd(2'd1, x, y);
    chk("t5_hit_y_held", y, 442);
    rd(2'd0, x, y);
    chk("t5_slot0_y", y, 374);
    bus.fire = 1'b1;
    n = 0;
    do begin frame(); n++; end while (f_acc == 0 && n < 20);
    bus.fire = 1'b0;
    chk("t5_frames_to_refill", n, 15);
    chk("t5_refilled", bus.shot_active, 4'b0011);
    rd(2'd1, x, y);
    chk("t5_refill_y", y, 442);
    rd(2'd0, x, y);
    chk("t5_slot0_y2", y, 314);

    // draw window and reset mid-sequence
    do_reset();
    bus.rd_slot = 2'd0;
    bus.fire = 1'b1;
    frame();
    bus.fire = 1'b0;
    bus.DrawX = 10'd321; bus.DrawY = 10'd445; #1;
    chk("t6_in", bus.is_shot, 1);
    bus.DrawX = 10'd322; #1;
    chk("t6_x_out", bus.is_shot, 0);
    bus.DrawX = 10'd321; bus.DrawY = 10'd438; #1;
    chk("t6_y_out", bus.is_shot, 0);
    step(1);
    bus.DrawY = 10'd439; #1;
    chk("t6_y_edge", bus.is_shot, 1);
    bus.DrawX = 10'd319; bus.DrawY = 10'd445; #1;
    chk("t6_x_left", bus.is_shot, 1);
    bus.DrawX = 10'd318; #1;
    chk("t6_x_left_out", bus.is_shot, 0);
    step(1);
    bus.DrawX = 10'd321;
    bus.frame_clk = 1'b1;
    step(3);
    bus.frame_clk = 1'b0;
    step(2);
    chk("t6_busy_adv2", bus.busy, 1);
    Reset = 1'b1;
    step(1);
    chk("t6_rst_active", bus.shot_active, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_is_shot", bus.is_shot, 0);
    Reset = 1'b0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
